crc16_checker: RTL

// - Receive-side stage downstream of the parallel CRC-16 generator.
// - Consumes the 50-bit codeword {data[33:0], crc[15:0]}.
// - Recomputes CRC-16 over the zero-padded 40-bit payload, one byte per clock, and compares it with the received CRC.
// - Emits the payload with a pass/fail verdict over a valid/ready handshake.

---
 rtl/crc16_checker.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/crc16_checker.sv
// ---------------------------------------------------------------------------
// crc16_checker
//
// Receive-side CRC-16 check stage. A 50-bit codeword {data[33:0], crc_rx[15:0]}
// is accepted over a valid/ready handshake. The checker then recomputes the
// CRC over the zero-padded 40-bit payload {6'b0, data} one byte per clock,
// most significant byte first. After the last byte it presents the payload,
// the recomputed CRC and a pass/fail verdict until downstream accepts it.
//
// CRC flavour: polynomial POLY, non-reflected, MSB-first, preset INIT at the
// start of every frame, no final XOR.
//
// Ports
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous, active-low reset
//   in_valid   in   1         codeword on in_code is valid
//   in_ready   out  1         checker can accept a codeword (IDLE only)
//   in_code    in   50        {data[33:0], crc_rx[15:0]}
//   out_valid  out  1         result valid, held until accepted
//   out_ready  in   1         downstream accepts the result
//   out_data   out  34        payload of the checked frame
//   crc_calc   out  16        locally recomputed CRC
//   crc_ok     out  1         crc_calc == crc_rx (0 when out_valid=0)
//   crc_err    out  1         crc_calc != crc_rx (0 when out_valid=0)
//   err_count  out  ERRCNT_W  saturating count of failed frames
//
// Optional feature
//   CRC_CHK_ERRCNT_EN  when defined, err_count counts every accepted result
//                      that carried crc_err=1, saturating at all-ones and
//                      cleared only by reset. When undefined, err_count is
//                      tied to zero and no counter is built.
//
// Timing: out_valid rises 5 clocks after the accepting edge; with out_ready
// tied high a new frame can be accepted every 7 clocks. All outputs come
// straight from flops.
// ---------------------------------------------------------------------------
module crc16_checker #(
    parameter logic [15:0] POLY     = 16'h8005,
    parameter logic [15:0] INIT     = 16'h0000,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [49:0]         in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [33:0]         out_data,
    output logic [15:0]         crc_calc,
    output logic                crc_ok,
    output logic                crc_err,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One byte of CRC-16: fold the byte into the top of the register, then
    // eight MSB-first shifts with conditional XOR of the polynomial.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [7:0]  byte_in);
        logic [15:0] c;
        c = crc_in ^ {byte_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t      state_r;
    state_t      next_state_s;

    logic [33:0] data_r;
    logic [15:0] crc_rx_r;
    logic [15:0] crc_r;
    logic [2:0]  byte_idx_r;

    logic [7:0]  cur_byte_s;
    logic [15:0] crc_next_s;

    logic        in_ready_r;
    logic        out_valid_r;
    logic [33:0] out_data_r;
    logic [15:0] crc_calc_r;
    logic        crc_ok_r;
    logic        crc_err_r;

    // Byte selection from the zero-padded payload; byte 4 holds the six pad
    // bits above data[33:32].
    always_comb begin
        cur_byte_s = 8'h00;
        case (byte_idx_r)
            3'd4:    cur_byte_s = {6'b00_0000, data_r[33:32]};
            3'd3:    cur_byte_s = data_r[31:24];
            3'd2:    cur_byte_s = data_r[23:16];
            3'd1:    cur_byte_s = data_r[15:8];
            3'd0:    cur_byte_s = data_r[7:0];
            default: cur_byte_s = 8'h00;
        endcase
        crc_next_s = crc_step(crc_r, cur_byte_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; an out-of-range byte index sends CALC back to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (byte_idx_r > 3'd4) begin
                    next_state_s = IDLE;
                end else if (byte_idx_r == 3'd0) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath: frame capture, byte-serial CRC, and registered result/verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r      <= 34'h0;
            crc_rx_r    <= 16'h0000;
            crc_r       <= 16'h0000;
            byte_idx_r  <= 3'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 34'h0;
            crc_calc_r  <= 16'h0000;
            crc_ok_r    <= 1'b0;
            crc_err_r   <= 1'b0;
        end else begin
            // in_ready mirrors the state we are about to enter.
            in_ready_r <= (next_state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_code[49:16];
                        crc_rx_r   <= in_code[15:0];
                        crc_r      <= INIT;
                        byte_idx_r <= 3'd4;
                    end
                end
                CALC: begin
                    crc_r <= crc_next_s;
                    if (byte_idx_r != 3'd0) begin
                        byte_idx_r <= byte_idx_r - 3'd1;
                    end
                    // The last byte's CRC goes straight into the result flops so
                    // the verdict is valid in the same cycle as out_valid.
                    if (next_state_s == DONE) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= data_r;
                        crc_calc_r  <= crc_next_s;
                        crc_ok_r    <= (crc_next_s == crc_rx_r);
                        crc_err_r   <= (crc_next_s != crc_rx_r);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        crc_ok_r    <= 1'b0;
                        crc_err_r   <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    crc_ok_r    <= 1'b0;
                    crc_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign crc_calc  = crc_calc_r;
    assign crc_ok    = crc_ok_r;
    assign crc_err   = crc_err_r;

`ifdef CRC_CHK_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_r;

    // Saturating failed-frame counter, stepped on the result handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_r <= {ERRCNT_W{1'b0}};
        end else if ((state_r == DONE) && out_ready && crc_err_r &&
                     (err_count_r != {ERRCNT_W{1'b1}})) begin
            err_count_r <= err_count_r + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = {ERRCNT_W{1'b0}};
`endif

endmodule
